toggle_cover_collector: RTL
===========================

TOGGLE_COVER_COLLECTOR -- requirements
Module: toggle_cover_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 29: number of monitored signal bits.
REQ-002 SHALL have parameter COVER_INDEX, default 0: global cover index of bit 0.
REQ-003 SHALL have parameter COVER_TOTAL, default 10906: size of the global cover space, used only by the index range check.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port sig  input  WIDTH  monitored signal bits.
REQ-007 SHALL have port enable  input  1  toggle detection enable.
REQ-008 SHALL have port clear  input  1  clears all coverage history.
REQ-009 SHALL have port valid  output  WIDTH  one-cycle toggle pulses, one per bit, for the downstream toggle reporter.
REQ-010 SHALL have port covered  output  WIDTH  sticky per-bit "toggled at least once" map.
REQ-011 SHALL have port covered_cnt  output  $clog2(WIDTH+1)  population count of covered.
REQ-012 SHALL have port all_covered  output  1  high when covered_cnt == WIDTH.
REQ-013 SHALL have port rpt_valid  output  1  first-hit report available.
REQ-014 SHALL have port rpt_ready  input  1  report consumer ready.
REQ-015 SHALL have port rpt_index  output  IDX_W  global index (COVER_INDEX + bit) of the reported first hit.

Function
REQ-016 SHALL register sig into prev every cycle, regardless of enable or clear.
REQ-017 SHALL set an internal primed flag one cycle after reset deasserts, so the first sample after reset never produces a toggle.
REQ-018 SHALL drive valid[i] registered: next valid[i] = primed & enable & (sig[i] != prev[i]), giving 1-cycle latency from the sampling edge.
REQ-019 SHALL count both 0->1 and 1->0 transitions as toggles.
REQ-020 SHALL set covered[i] and pending[i] on the cycle valid[i] is asserted, if covered[i] was 0.
REQ-021 SHALL update covered_cnt on the same edge as covered; the count cannot exceed WIDTH.
REQ-022 SHALL hold the report in an output register: when the register is empty, or a transfer occurs this cycle, and pending is nonzero, load the lowest set pending bit and clear that bit in pending.
REQ-023 SHALL define a transfer as rpt_valid & rpt_ready; on a transfer with nothing pending, rpt_valid drops next cycle.
REQ-024 SHALL hold rpt_index stable while rpt_valid & !rpt_ready, even if lower-numbered bits become pending.
REQ-025 SHALL, on clear, zero covered, pending, covered_cnt and rpt_valid next cycle; clear wins over a simultaneous first hit or transfer; valid pulses are unaffected.
REQ-026 SHALL give multiple simultaneous first hits all pending, reported in ascending bit order, one per transfer.

Reset
REQ-027 SHALL on reset drive prev, primed, valid, covered, pending, covered_cnt, all_covered, rpt_valid and rpt_index to 0.
REQ-028 SHALL abandon an in-flight report on reset mid-handshake without a completing transfer.

Configuration
REQ-029 SHALL recognise macro TOGGLE_COVER_REPORT_STREAM_EN: when defined, pending, the report register and the rpt_* handshake are built as above.
REQ-030 SHALL, when TOGGLE_COVER_REPORT_STREAM_EN is undefined, omit pending and the report logic, tie rpt_valid and rpt_index to 0 and ignore rpt_ready; valid, covered, covered_cnt and all_covered are unchanged.

Structure
REQ-031 SHALL take IDX_W (32) and the default COVER_TOTAL from shared package toggle_cover_pkg.
REQ-032 SHALL implement lowest-set-bit selection in sub-module cover_prio_enc (input WIDTH bits; outputs found and index).
REQ-033 SHALL check under simulation only that COVER_INDEX + WIDTH <= COVER_TOTAL.

Verification
REQ-034 SHALL cover: reset, then sig held 0x0 with enable=1 for 3 cycles -> valid stays 0 and the primed first sample yields no pulse.
REQ-035 SHALL cover: sig bit 3 goes 0->1->0 on consecutive cycles -> valid[3] high for 2 cycles, covered=0x8, covered_cnt=1, exactly one report with rpt_index=COVER_INDEX+3.
REQ-036 SHALL cover: bits 5 and 2 toggle together with rpt_ready=0 for 4 cycles, then bit 0 toggles -> rpt_index stays at +2 while stalled; after ready=1 the order is +2, +0, +5.
REQ-037 SHALL cover: all 29 bits toggle -> all_covered=1, covered_cnt=29; a further toggle produces no new report.
REQ-038 SHALL cover: clear asserted in the same cycle a new first hit and a transfer occur -> covered=0, covered_cnt=0, rpt_valid=0 next cycle.
REQ-039 SHALL cover: enable=0 while sig toggles -> valid=0 and no coverage change; reset asserted mid-stall -> rpt_valid=0 next cycle.

Source files
------------

// File: rtl/toggle_cover_pkg.sv
// Shared constants and helpers for the toggle coverage collector and its priority encoder.
package toggle_cover_pkg;

  localparam int IDX_W               = 32;
  localparam int COVER_TOTAL_DEFAULT = 10906;

  typedef logic [IDX_W-1:0] cover_idx_t;

  // Bit-index width for a vector of w bits; never collapses to zero width.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the next pending first hit.
module cover_prio_enc
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH = 29,
  parameter int IW    = idx_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic             found,
  output logic [IW-1:0]    index
);

  // Scan from the top down so the last match written is the lowest set bit.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IW'(i);
      end
    end
  end

endmodule

// File: rtl/toggle_cover_collector.sv
// Per-bit toggle detector with sticky coverage map, population count and an optional
// first-hit report stream (enabled by macro TOGGLE_COVER_REPORT_STREAM_EN).
module toggle_cover_collector
  import toggle_cover_pkg::*;
#(
  parameter int WIDTH       = 29,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = COVER_TOTAL_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           sig,
  input  logic                       enable,
  input  logic                       clear,
  output logic [WIDTH-1:0]           valid,
  output logic [WIDTH-1:0]           covered,
  output logic [$clog2(WIDTH+1)-1:0] covered_cnt,
  output logic                       all_covered,
  output logic                       rpt_valid,
  input  logic                       rpt_ready,
  output logic [IDX_W-1:0]           rpt_index
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] prev;
  logic             primed;
  logic [WIDTH-1:0] valid_next;
  logic [WIDTH-1:0] covered_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    valid_next   = (primed && enable) ? (sig ^ prev) : '0;
    covered_next = clear ? '0 : (covered | valid_next);
    cnt_next     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next = cnt_next + CNT_W'(covered_next[i]);
    end
  end

  // prev tracks sig unconditionally so re-enabling never reports a stale edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev        <= '0;
      primed      <= 1'b0;
      valid       <= '0;
      covered     <= '0;
      covered_cnt <= '0;
      all_covered <= 1'b0;
    end else begin
      prev        <= sig;
      primed      <= 1'b1;
      valid       <= valid_next;
      covered     <= covered_next;
      covered_cnt <= cnt_next;
      all_covered <= (cnt_next == CNT_W'(WIDTH));
    end
  end

`ifdef TOGGLE_COVER_REPORT_STREAM_EN
  localparam int IW = idx_width(WIDTH);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] first_hit;
  logic [WIDTH-1:0] load_mask;
  logic             pend_found;
  logic [IW-1:0]    pend_idx;
  logic             load;

  cover_prio_enc #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_prio (
    .req   (pending),
    .found (pend_found),
    .index (pend_idx)
  );

  always_comb begin
    first_hit = valid_next & ~covered;
    load      = pend_found && (!rpt_valid || rpt_ready);
    load_mask = load ? (WIDTH'(1) << pend_idx) : '0;
  end

  // The report register only reloads when empty or draining, so a stalled index holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending   <= '0;
      rpt_valid <= 1'b0;
      rpt_index <= '0;
    end else if (clear) begin
      pending   <= '0;
      rpt_valid <= 1'b0;
    end else begin
      pending <= (pending & ~load_mask) | first_hit;
      if (load) begin
        rpt_valid <= 1'b1;
        rpt_index <= IDX_W'(COVER_INDEX) + IDX_W'(pend_idx);
      end else if (rpt_ready) begin
        rpt_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_ready;

  assign unused_ready = rpt_ready;
  assign rpt_valid    = 1'b0;
  assign rpt_index    = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    assert (COVER_INDEX + WIDTH <= COVER_TOTAL)
      else $error("cover index range exceeds COVER_TOTAL");
  end
`endif

endmodule
